flappy_compositor: RTL

Parametrised, pipelined pixel compositor for the flappy game's VGA path. It takes the VGA scan position, per-frame mario and pipe descriptors, and synchronous-ROM read data. It produces the final 12-bit pixel colour, a matching delayed sync/blank, and a per-frame mario/pipe collision flag. It sits between the game logic and `vga_sync`/the sprite ROMs. It supports N pipe groups, a per-group gap height, and tear-free frame-latched positions.

---
 rtl/flappy_compositor.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/flappy_compositor.sv
`default_nettype none
// ============================================================================
// Module   : flappy_compositor
// Brief    : 3-stage VGA compositor (background, N pipe groups, mario) with
//            frame-latched geometry. Define FLAPPY_COLLIDE_EN to build the
//            mario/pipe collision detector (collide/fail).
// Revision : 1.0
// ============================================================================
module flappy_compositor #(
    parameter int          N_PIPES  = 3,
    parameter int          PIPE_W   = 50,
    parameter int          HEAD_H   = 23,
    parameter int          MARIO_X  = 10,
    parameter int          MARIO_SZ = 16,
    parameter int          BG_W     = 80,
    parameter int          BG_SHIFT = 3,
    parameter logic [11:0] KEY      = 12'h06F
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [9:0]             x,
    input  logic [9:0]             y,
    input  logic                   video_on,
    input  logic                   hs_i,
    input  logic                   vs_i,
    input  logic                   frame_start,
    input  logic [9:0]             mario_y,
    input  logic [32*N_PIPES-1:0]  pipes,
    output logic [12:0]            bg_addr,
    output logic [7:0]             mario_addr,
    output logic [10:0]            head_addr,
    output logic [5:0]             body_addr,
    input  logic [11:0]            bg_d,
    input  logic [11:0]            mario_d,
    input  logic [11:0]            head_d,
    input  logic [11:0]            body_d,
    output logic [11:0]            rgb,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   collide,
    output logic                   fail
);
    localparam logic [11:0] HEAD_H12   = 12'(HEAD_H);
    localparam logic [11:0] PIPE_W12   = 12'(PIPE_W);
    localparam logic [10:0] PIPE_W11   = 11'(PIPE_W);
    localparam logic [11:0] MARIO_X12  = 12'(MARIO_X);
    localparam logic [11:0] MARIO_SZ12 = 12'(MARIO_SZ);
    localparam logic [15:0] BG_W16     = 16'(BG_W);

    logic [9:0]         sh_mario_y;
    logic [9:0]         t_arr    [N_PIPES];
    logic [7:0]         g_arr    [N_PIPES];
    logic [10:0]        diff_arr [N_PIPES];
    logic [N_PIPES-1:0] cov;

    logic [11:0] x12, y12, my12;
    assign x12  = {2'b00, x};
    assign y12  = {2'b00, y};
    assign my12 = {2'b00, sh_mario_y};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_mario_y <= 10'd0;
        end else if (frame_start) begin
            sh_mario_y <= mario_y;
        end
    end

    generate
        for (genvar i = 0; i < N_PIPES; i++) begin : g_pipe
            logic       en_r;
            logic [9:0] a_r;
            logic [9:0] t_r;
            logic [7:0] g_r;
            logic       unused_rsvd;

            assign unused_rsvd = ^pipes[32*i+30 -: 3];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    en_r <= 1'b0;
                    a_r  <= 10'd0;
                    t_r  <= 10'd0;
                    g_r  <= 8'd0;
                end else if (frame_start) begin
                    en_r <= pipes[32*i+31];
                    a_r  <= pipes[32*i+19 -: 10];
                    t_r  <= pipes[32*i+9 -: 10];
                    g_r  <= pipes[32*i+27 -: 8];
                end
            end

            // 11-bit signed difference: x left of A is negative, never a wrap
            assign diff_arr[i] = {1'b0, x} - {1'b0, a_r};
            assign cov[i]      = en_r && !diff_arr[i][10] && (diff_arr[i] < PIPE_W11);
            assign t_arr[i]    = t_r;
            assign g_arr[i]    = g_r;
        end
    endgenerate

    logic        any_pipe;
    logic [9:0]  sel_t;
    logic [7:0]  sel_g;
    logic [10:0] sel_dx;

    always_comb begin
        any_pipe = 1'b0;
        sel_t    = 10'd0;
        sel_g    = 8'd0;
        sel_dx   = 11'd0;
        for (int i = N_PIPES - 1; i >= 0; i--) begin
            if (cov[i]) begin
                any_pipe = 1'b1;
                sel_t    = t_arr[i];
                sel_g    = g_arr[i];
                sel_dx   = diff_arr[i];
            end
        end
    end

    logic [11:0] t12, top12, b12, hr;
    logic        in_top, in_bot, in_body, in_box;
    logic        head_n, body_n;

    always_comb begin
        t12   = {2'b00, sel_t};
        top12 = t12 - HEAD_H12;
        b12   = t12 + {4'b0000, sel_g};
        // a negative top12 means the top head is clipped at row 0
        in_top  = (top12[11] || (y12 >= top12)) && (y12 < t12);
        in_bot  = (y12 >= b12) && (y12 < b12 + HEAD_H12);
        in_body = (!top12[11] && (y12 < top12)) || (y12 >= b12 + HEAD_H12);
        hr      = in_top ? (y12 - top12) : (HEAD_H12 - 12'd1 - (y12 - b12));
        head_n  = any_pipe && (in_top || in_bot);
        body_n  = any_pipe && in_body;
        in_box  = (x12 >= MARIO_X12) && (x12 < MARIO_X12 + MARIO_SZ12) &&
                  (y12 >= my12) && (y12 < my12 + MARIO_SZ12);
    end

    logic s1_vid, s1_mario, s1_head, s1_body, s1_hs, s1_vs;
    logic s2_vid, s2_mario, s2_head, s2_body, s2_hs, s2_vs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bg_addr    <= 13'd0;
            mario_addr <= 8'd0;
            head_addr  <= 11'd0;
            body_addr  <= 6'd0;
            s1_vid     <= 1'b0;
            s1_mario   <= 1'b0;
            s1_head    <= 1'b0;
            s1_body    <= 1'b0;
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
        end else begin
            bg_addr    <= 13'(16'(y12 >> BG_SHIFT) * BG_W16 + 16'(x12 >> BG_SHIFT));
            mario_addr <= in_box ? 8'((y12 - my12) * MARIO_SZ12 + (x12 - MARIO_X12)) : 8'd0;
            head_addr  <= 11'(hr * PIPE_W12 + {1'b0, sel_dx});
            body_addr  <= 6'(sel_dx);
            s1_vid     <= video_on;
            s1_mario   <= in_box;
            s1_head    <= head_n;
            s1_body    <= body_n;
            s1_hs      <= hs_i;
            s1_vs      <= vs_i;
        end
    end

    // ROM data returns alongside the stage-2 flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vid   <= 1'b0;
            s2_mario <= 1'b0;
            s2_head  <= 1'b0;
            s2_body  <= 1'b0;
            s2_hs    <= 1'b0;
            s2_vs    <= 1'b0;
        end else begin
            s2_vid   <= s1_vid;
            s2_mario <= s1_mario;
            s2_head  <= s1_head;
            s2_body  <= s1_body;
            s2_hs    <= s1_hs;
            s2_vs    <= s1_vs;
        end
    end

    logic        mario_opaque;
    logic [11:0] pix;

    always_comb begin
        mario_opaque = s2_mario && (mario_d != KEY);
        if (!s2_vid) begin
            pix = 12'h000;
        end else if (mario_opaque) begin
            pix = mario_d;
        end else if (s2_head) begin
            pix = head_d;
        end else if (s2_body) begin
            pix = body_d;
        end else begin
            pix = bg_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb  <= 12'h000;
            hs_o <= 1'b0;
            vs_o <= 1'b0;
        end else begin
            rgb  <= pix;
            hs_o <= s2_hs;
            vs_o <= s2_vs;
        end
    end

`ifdef FLAPPY_COLLIDE_EN
    logic hit;
    logic hit_now;

    assign hit_now = s2_vid && mario_opaque && (s2_head || s2_body);

    // a hit on the frame_start edge belongs to the frame that just ended
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit     <= 1'b0;
            collide <= 1'b0;
            fail    <= 1'b0;
        end else if (frame_start) begin
            collide <= hit || hit_now;
            fail    <= (hit || hit_now) && !collide;
            hit     <= 1'b0;
        end else begin
            hit     <= hit || hit_now;
            fail    <= 1'b0;
        end
    end
`else
    assign collide = 1'b0;
    assign fail    = 1'b0;
`endif

endmodule
`default_nettype wire
